// File: rtl/led_feedback_arbiter.sv
// led_feedback_arbiter: shares one feedback LED among N_SRC event sources,
// latching request pulses and playing an ON/GAP blink pattern per grant.
//
// Ports:
//   clk          system clock
//   reset_fixed  synchronous active-high reset
//   req          one-cycle request pulses, one bit per source
//   clear        synchronous flush of all pending requests
//   led_out      shared LED drive
//   grant        one-hot owner of the running pattern, 0 when idle
//   busy         high while a pattern is running (ON or GAP)
//   pending      latched requests not yet served
//   merged       one-cycle pulse when a req hits an already-pending source
//
// Build option: define LED_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority (lowest index first).
module led_feedback_arbiter #(
    parameter int N_SRC    = 4,
    parameter int ON_TIME  = 12_500_000,
    parameter int GAP_TIME = 2_500_000,
    parameter int BLINKS   = 1,
    parameter int CNT_W    = 24
) (
    input  logic             clk,
    input  logic             reset_fixed,
    input  logic [N_SRC-1:0] req,
    input  logic             clear,
    output logic             led_out,
    output logic [N_SRC-1:0] grant,
    output logic             busy,
    output logic [N_SRC-1:0] pending,
    output logic             merged
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP
    } state_t;

    localparam logic [CNT_W-1:0] ON_END  = CNT_W'(ON_TIME);
    localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_TIME);
    localparam logic [CNT_W-1:0] T_ONE   = CNT_W'(1);
    localparam logic [3:0]       BLK     = 4'(BLINKS);

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] tmr;
    logic [CNT_W-1:0] tmr_d;
    logic [3:0]       bcnt;
    logic [3:0]       bcnt_d;
    logic             led_d;
    logic [N_SRC-1:0] grant_d;
    logic [N_SRC-1:0] served;
    logic [N_SRC-1:0] sel_oh;
    logic             any_pend;

    assign any_pend = |pending;

`ifdef LED_ARB_RR_EN
    localparam int PW = $clog2(N_SRC);

    logic [PW-1:0] ptr;
    logic [PW-1:0] sel_idx;
    logic [PW-1:0] cand;

    // Walk the search order backwards so the earliest candidate
    // after the pointer is the one left standing.
    always_comb begin
        sel_oh  = '0;
        sel_idx = ptr;
        cand    = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            cand = PW'((int'(ptr) + k) % N_SRC);
            if (pending[cand]) begin
                sel_oh       = '0;
                sel_oh[cand] = 1'b1;
                sel_idx      = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_fixed) begin
            ptr <= PW'(N_SRC - 1);
        end else if (|served) begin
            ptr <= sel_idx;
        end
    end
`else
    // Isolate the lowest set bit: fixed priority, index 0 first.
    assign sel_oh = pending & (~pending + N_SRC'(1));
`endif

    always_comb begin
        state_d = state;
        tmr_d   = tmr;
        bcnt_d  = bcnt;
        led_d   = led_out;
        grant_d = grant;
        served  = '0;
        unique case (state)
            S_IDLE: begin
                if (any_pend) begin
                    state_d = S_ON;
                    grant_d = sel_oh;
                    served  = sel_oh;
                    tmr_d   = T_ONE;
                    bcnt_d  = 4'd1;
                    led_d   = 1'b1;
                end
            end
            S_ON: begin
                if (tmr == ON_END) begin
                    state_d = S_GAP;
                    tmr_d   = T_ONE;
                    led_d   = 1'b0;
                end else begin
                    tmr_d = tmr + T_ONE;
                end
            end
            S_GAP: begin
                if (tmr == GAP_END) begin
                    if (bcnt < BLK) begin
                        state_d = S_ON;
                        bcnt_d  = bcnt + 4'd1;
                        tmr_d   = T_ONE;
                        led_d   = 1'b1;
                    end else if (any_pend) begin
                        // Hand over directly, no idle cycle between owners.
                        state_d = S_ON;
                        grant_d = sel_oh;
                        served  = sel_oh;
                        tmr_d   = T_ONE;
                        bcnt_d  = 4'd1;
                        led_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                        tmr_d   = '0;
                        bcnt_d  = '0;
                    end
                end else begin
                    tmr_d = tmr + T_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                led_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_fixed) begin
            state   <= S_IDLE;
            tmr     <= '0;
            bcnt    <= '0;
            led_out <= 1'b0;
            grant   <= '0;
            busy    <= 1'b0;
            pending <= '0;
            merged  <= 1'b0;
        end else begin
            state   <= state_d;
            tmr     <= tmr_d;
            bcnt    <= bcnt_d;
            led_out <= led_d;
            grant   <= grant_d;
            busy    <= (state_d != S_IDLE);
            merged  <= |(req & pending);
            // A req arriving as its source is served stays pending.
            if (clear) begin
                pending <= '0;
            end else begin
                pending <= (pending & ~served) | req;
            end
        end
    end

endmodule

// File: tb/tb_led_feedback_arbiter.sv
// tb_led_feedback_arbiter: table vectors, corner sequences and a
// randomized run against a pattern-position reference model.
module tb_led_feedback_arbiter;

    localparam int N    = 4;
    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int BLK  = 2;
    localparam int PER  = ON + GAP;
    localparam int PLEN = BLK * PER;

    logic         clk;
    logic         reset_fixed;
    logic [N-1:0] req;
    logic         clear;
    logic         led_out;
    logic [N-1:0] grant;
    logic         busy;
    logic [N-1:0] pending;
    logic         merged;

    int n_pass;
    int n_tot;

    led_feedback_arbiter #(
        .N_SRC   (N),
        .ON_TIME (ON),
        .GAP_TIME(GAP),
        .BLINKS  (BLK),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .reset_fixed(reset_fixed),
        .req        (req),
        .clear      (clear),
        .led_out    (led_out),
        .grant      (grant),
        .busy       (busy),
        .pending    (pending),
        .merged     (merged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner index (-1 idle) and position in its pattern.
    logic [N-1:0] m_pend;
    logic         m_merged;
    int           m_owner;
    int           m_pos;
`ifdef LED_ARB_RR_EN
    int           m_ptr;
`endif

    function automatic int pick(input logic [N-1:0] p);
`ifdef LED_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (p[2'((m_ptr + k) % N)]) return (m_ptr + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (p[2'(i)]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_edge(input logic [N-1:0] r, input logic c,
                              input logic rs);
        logic [N-1:0] srv;
        int nxt;
        if (rs) begin
            m_pend   = '0;
            m_merged = 1'b0;
            m_owner  = -1;
            m_pos    = 0;
`ifdef LED_ARB_RR_EN
            m_ptr    = N - 1;
`endif
            return;
        end
        srv = '0;
        nxt = -1;
        if (m_owner < 0) begin
            if (m_pend != 0) nxt = pick(m_pend);
        end else begin
            m_pos++;
            if (m_pos == PLEN) begin
                m_owner = -1;
                if (m_pend != 0) nxt = pick(m_pend);
            end
        end
        if (nxt >= 0) begin
            m_owner = nxt;
            m_pos   = 0;
            srv     = N'(1) << nxt;
`ifdef LED_ARB_RR_EN
            m_ptr   = nxt;
`endif
        end
        m_merged = |(r & m_pend);
        m_pend   = c ? '0 : ((m_pend & ~srv) | r);
    endtask

    function automatic logic [10:0] model_vec();
        logic         led;
        logic [N-1:0] g;
        led = (m_owner >= 0) && ((m_pos % PER) < ON);
        g   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        return {led, g, (m_owner >= 0), m_pend, m_merged};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {led_out, grant, busy, pending, merged};
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    task automatic step(input logic [N-1:0] r, input logic c,
                        input logic rs);
        req         = r;
        clear       = c;
        reset_fixed = rs;
        @(posedge clk);
        model_edge(r, c, rs);
        #1;
    endtask

    task automatic do_reset();
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic [N-1:0] r;
        logic         c;
        logic         led;
        logic [N-1:0] g;
        logic         b;
        logic [N-1:0] p;
        logic         m;
    } vec_t;

    vec_t         tbl[14];
    logic [N-1:0] hist[30];
    logic [N-1:0] prev;
    int           cnt_m;
    int           cnt_s;
    int           seen1;

    initial begin
        n_pass = 0;
        n_tot  = 0;
        req    = '0;
        clear  = 1'b0;
        reset_fixed = 1'b1;

        // Single request on source 2: two blinks of ON=4 / GAP=2.
        tbl[0]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0};
        tbl[1]  = '{4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[7]  = '{4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[10] = '{4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[13] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};

        do_reset();
        chk("reset_state", 32'(dut_vec()), 32'd0);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].c, 1'b0);
            chk($sformatf("tbl[%0d]", i), 32'(dut_vec()),
                32'({tbl[i].led, tbl[i].g, tbl[i].b, tbl[i].p, tbl[i].m}));
        end

        // Simultaneous requests: source 1 then 3, back to back.
        do_reset();
        step(4'b1010, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            step('0, 1'b0, 1'b0);
            hist[i] = grant;
            chk("prio_model", 32'(dut_vec()), 32'(model_vec()));
        end
        chk("prio_first", 32'(hist[0]), 32'b0010);
        chk("prio_last1", 32'(hist[11]), 32'b0010);
        chk("prio_next", 32'(hist[12]), 32'b1000);
        chk("prio_end", 32'(hist[24]), 32'b0000);

        // Repeat req on an already-pending source coalesces.
        do_reset();
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        cnt_m = 0;
        cnt_s = 0;
        prev  = grant;
        for (int i = 0; i < 40; i++) begin
            step((i == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
            if (merged) cnt_m++;
            if (grant == 4'b0001 && prev != 4'b0001) cnt_s++;
            prev = grant;
            chk("merge_model", 32'(dut_vec()), 32'(model_vec()));
        end
        chk("merge_pulses", 32'(cnt_m), 32'd1);
        chk("merge_patterns", 32'(cnt_s), 32'd1);
        chk("merge_idle", 32'(busy), 32'd0);

        // Clear during GAP drops the queued source 1.
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk("clr_in_gap", 32'({led_out, busy}), 32'b01);
        step(4'b0000, 1'b1, 1'b0);
        chk("clr_pending", 32'(pending), 32'd0);
        seen1 = 0;
        for (int i = 0; i < 20; i++) begin
            step('0, 1'b0, 1'b0);
            if (grant == 4'b0010) seen1++;
            chk("clr_model", 32'(dut_vec()), 32'(model_vec()));
        end
        chk("clr_src1_never", 32'(seen1), 32'd0);
        chk("clr_grant_end", 32'(grant), 32'd0);

        // Reset during the second blink's ON phase.
        do_reset();
        step(4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step((i == 2) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
        end
        chk("rst_mid_on", 32'({led_out, grant}), 32'b1_0100);
        step('0, 1'b0, 1'b1);
        chk("rst_mid_out", 32'({led_out, busy, pending, grant}),
            32'd0);
        step(4'b0001, 1'b0, 1'b0);
        chk("rst_lat_k", 32'({led_out, grant, pending}),
            32'b0_0000_0001);
        step(4'b0000, 1'b0, 1'b0);
        chk("rst_lat_k1", 32'({led_out, grant, pending}),
            32'b1_0001_0000);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r;
            for (int b = 0; b < N; b++) begin
                r[2'(b)] = ($urandom_range(0, 15) == 0);
            end
            step(r, ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 499) == 0));
            chk($sformatf("rand[%0d]", i), 32'(dut_vec()),
                32'(model_vec()));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
